memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Round-robin scheduler that shares the single-port 128×8 program/data memory between four requesters: instruction fetch, data load/store, reserve and system-call/display. Each requester posts one access at a time with a level request; the arbiter serialises accesses, drives the memory for one cycle, and returns a one-cycle `done` pulse with read data. It sits between the processor core and the memory array and takes over the role of the core's hand-sequenced memory `state`/`en` signals.

## Interface
- `ADDR_W`, default 7: memory address width.
- `DATA_W`, default 8: memory data width.
- Port count is fixed at 4. Port *i* occupies slice `[i*W +: W]` of every packed bus.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 4: per-port access request, a level signal.
- `we` in 4: per-port write enable (1 = write, 0 = read).
- `addr` in 4·ADDR_W: per-port address.
- `wdata` in 4·DATA_W: per-port write data.
- `done` out 4: one-hot, one-cycle completion pulse.
- `rdata` out DATA_W: read data, valid while `done` is high for a read.
- `busy` out 1: high while an access is in flight (state ≠ IDLE).
- `mem_en` out 1: memory strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: synchronous memory output, valid one cycle after the `mem_en` cycle.

## Operation
- FSM states are IDLE, ACCESS and WAIT.
- **IDLE**
  - The eligible set is `req & ~done`. Masking with `done` stops a requester that is still holding `req` on the cycle it sees `done` from being re-granted.
  - If the eligible set is non-empty, pick the winner by searching ports `last+1, last+2, last+3, last` (mod 4).
  - Latch the winner's `we`, `addr` and `wdata` into `mem_*` and set `mem_en`=1. Record the winner in `cur`, then go to ACCESS.
- **ACCESS**
  - `mem_en` is high for exactly this cycle; the memory samples at the closing edge.
  - At that edge: `mem_en`←0, go to WAIT.
- **WAIT**
  - At the closing edge: `rdata`←`mem_rdata` if the access was a read; `rdata` holds its previous value on a write.
  - Also at that edge: `done[cur]`←1, `last`←`cur`, go to IDLE.
- `done` is cleared at every edge where it is not being set.
- Requester contract:
  - Hold `req`, `we`, `addr` and `wdata` stable from assertion until `done` is seen.
  - Deassert `req` at or after the `done` edge.
  - Changing any of these fields while the request is pending is undefined only before grant; after grant the latched values are used.
- A request dropped before it is granted is simply never served. A request dropped after grant still completes and still pulses `done`.
- Reset values: state=IDLE, `last`=3 (so port 0 wins the first arbitration), `done`=0, `rdata`=0, `busy`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-operation:
  - Everything returns to the reset values at the reset edge and no `done` is issued.
  - If reset coincides with the ACCESS closing edge, the memory still samples `mem_en`=1, so a write commits. The requester must reissue after reset.

## Timing
- Edge E0 (IDLE with an eligible request) → ACCESS at E0 → WAIT at E1 → `done` and `rdata` visible after E2.
- Request-to-`done` latency is 3 cycles, counted from the first cycle `req` is high at an IDLE edge.
- Throughput is one access per 3 cycles. A new grant can happen at E3, the same edge at which `done` clears.
- With all four ports continuously requesting, the grant order is 0,1,2,3,0,… Every port is served within 12 cycles, so no port starves.
- Simultaneous new requests are resolved purely by the rotating pointer; there is no fixed priority.
- `busy` = (state ≠ IDLE). It is high for exactly 2 cycles per access.

## Structure
- Shared package `arb_pkg` holds:
  - the state encoding: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2;
  - `NPORTS`=4;
  - the port names as 2-bit constants: P_FETCH=0, P_DATA=1, P_RESERVE=2, P_SYS=3.
- Sub-module `rr_pick` is purely combinational:
  - inputs: `eligible[3:0]` and `last[1:0]`;
  - outputs: `valid` and `winner[1:0]`.
- The top level holds the FSM, the latch registers and the output registers.

## Test plan
- **Single read.** After reset, port 1 reads `addr`=7'h20, memory preloaded with 8'hA5. Expect `mem_en` high 1 cycle later with `mem_addr`=7'h20 and `mem_we`=0. Expect `done`=4'b0010 and `rdata`=8'hA5 three cycles after `req`.
- **Write then read.** Port 2 writes 8'h3C to 7'h1F, then port 0 reads 7'h1F. Expect `mem_we`=1 for 1 cycle, then `done`=4'b0100 with `rdata` unchanged from its prior value. Then expect `done`=4'b0001 with `rdata`=8'h3C.
- **Fairness.** All four ports hold `req` at the same cycle right after reset and drop it on their own `done`. Expect grants in order 0,1,2,3 at 3-cycle spacing, with `done` pulses exactly 3 cycles apart.
- **Held request.** Ports 0 and 3 both request continuously and never drop `req`. Expect the grants to alternate 0,3,0,3. No port is granted twice in a row while the other port is pending.
- **Done masking.** Port 1 holds `req` one cycle past `done`. Expect no second grant on the `done` cycle, and `busy` low in that cycle when no other port is requesting.
- **Reset mid-access.** Assert `reset` during WAIT of a port-0 read. Expect no `done`, every output at its reset value, and the next grant to go to port 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the four-port round-robin memory arbiter:
// FSM encoding, port count and the symbolic requester numbers.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam int NPORTS = 4;

    localparam logic [1:0] P_FETCH   = 2'd0;
    localparam logic [1:0] P_DATA    = 2'd1;
    localparam logic [1:0] P_RESERVE = 2'd2;
    localparam logic [1:0] P_SYS     = 2'd3;

endpackage

// File: rtl/memory_arbiter_rr_pick.sv
// Combinational round-robin picker: searches last+1, last+2, last+3, last
// (mod 4) and reports the first eligible port.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NPORTS-1:0] eligible,
    input  logic [1:0]        last,
    output logic              valid,
    output logic [1:0]        winner
);

    logic [1:0] cand;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the loop can leave it unassigned and infer a latch.
    always_comb begin
        valid  = 1'b0;
        winner = last;
        cand   = last;
        for (int i = 1; i <= NPORTS; i++) begin
            // 2-bit wrap gives the modulo-4 rotation for free; i=4 lands on last.
            cand = last + 2'(i);
            if (!valid && eligible[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises four requesters onto a single-port synchronous memory: one
// grant per three cycles, one-hot done pulse with read data.
module memory_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        we,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*DATA_W-1:0] wdata,
    output logic [NPORTS-1:0]        done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    state_t     state, state_next;
    logic [1:0] last, cur;
    logic [1:0] winner;
    logic       pick_valid;

    // A port still holding req in its done cycle must not win again at once.
    rr_pick u_pick (
        .eligible (req & ~done),
        .last     (last),
        .valid    (pick_valid),
        .winner   (winner)
    );

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see the pre-edge values of each other, regardless of order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pick_valid) state_next = ACCESS;
            ACCESS:  state_next = WAIT;
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= P_SYS;
            cur       <= P_FETCH;
            done      <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        mem_en    <= 1'b1;
                        mem_we    <= we[winner];
                        mem_addr  <= addr[winner*ADDR_W +: ADDR_W];
                        mem_wdata <= wdata[winner*DATA_W +: DATA_W];
                        cur       <= winner;
                    end
                end
                ACCESS: mem_en <= 1'b0;
                WAIT: begin
                    // mem_we still describes the access that just finished.
                    if (!mem_we) rdata <= mem_rdata;
                    done[cur] <= 1'b1;
                    last      <= cur;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter with a behavioural synchronous memory.
module tb_memory_arbiter;
    import arb_pkg::*;

    localparam int AW = 7;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        req, we, done;
    logic [4*AW-1:0]   addr;
    logic [4*DW-1:0]   wdata;
    logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
    logic              busy, mem_en, mem_we;
    logic [AW-1:0]     mem_addr;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .done(done), .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [128];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        int            port;
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] onehot;
        if (!reset && done != 4'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                e      = sb.pop_front();
                onehot = 4'b0001 << e.port;
                check("done_port", 32'(done), 32'(onehot));
                check("done_rdata", 32'(rdata), 32'(e.rdata));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        we[p]             = w;
        addr[p*AW +: AW]  = a;
        wdata[p*DW +: DW] = d;
        req[p]            = 1'b1;
    endtask

    task automatic expect_done(input int p, input logic [DW-1:0] rd, input int c);
        exp_t e;
        e.port  = p;
        e.rdata = rd;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    // Each requester drops req on its own done; bounded by a cycle budget.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((req != 4'b0 || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            req = req & ~done;
            n++;
        end
        if (n >= budget) check("drain_timeout", 32'(sb.size()), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"},      32'(done),      32'h0);
        check({tag, "_rdata"},     32'(rdata),     32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_mem_en"},    32'(mem_en),    32'h0);
        check({tag, "_mem_we"},    32'(mem_we),    32'h0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req   = 4'b0;
        we    = 4'b0;
        addr  = '0;
        wdata = '0;
        foreach (mem[i]) mem[i] = 8'h00;
        mem[7'h20] = 8'hA5;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single read by port 1.
        set_port(1, 1'b0, 7'h20, 8'h00);
        expect_done(1, 8'hA5, cyc + 3);
        @(negedge clk);
        check("rd_mem_en",   32'(mem_en),   32'h1);
        check("rd_mem_addr", 32'(mem_addr), 32'h20);
        check("rd_mem_we",   32'(mem_we),   32'h0);
        check("rd_busy",     32'(busy),     32'h1);
        @(negedge clk);
        check("rd_mem_en_off", 32'(mem_en), 32'h0);
        check("rd_busy_wait",  32'(busy),   32'h1);
        drain(20);

        // Port 2 writes, then port 0 reads back.
        set_port(2, 1'b1, 7'h1F, 8'h3C);
        expect_done(2, 8'hA5, cyc + 3);
        @(negedge clk);
        check("wr_mem_en",    32'(mem_en),    32'h1);
        check("wr_mem_we",    32'(mem_we),    32'h1);
        check("wr_mem_addr",  32'(mem_addr),  32'h1F);
        check("wr_mem_wdata", 32'(mem_wdata), 32'h3C);
        @(negedge clk);
        check("wr_mem_we_len", 32'(mem_en & mem_we), 32'h0);
        drain(20);
        set_port(0, 1'b0, 7'h1F, 8'h00);
        expect_done(0, 8'h3C, cyc + 3);
        drain(20);

        // Reset during WAIT of a port-0 read; last pointer was 0 before it.
        set_port(0, 1'b0, 7'h20, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("mid_state_wait", 32'(busy & ~mem_en), 32'h1);
        reset = 1'b1;
        req   = 4'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        set_port(0, 1'b0, 7'h1F, 8'h00);
        set_port(1, 1'b1, 7'h05, 8'h77);
        expect_done(0, 8'h3C, cyc + 3);
        expect_done(1, 8'h3C, cyc + 6);
        drain(30);
        check("mid_write_commit", 32'(mem[7'h05]), 32'h77);

        // Port 1 holds req one cycle beyond done: no re-grant.
        set_port(1, 1'b0, 7'h05, 8'h00);
        expect_done(1, 8'h77, cyc + 3);
        n = 0;
        while (done[1] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mask_saw_done", 32'(done[1]), 32'h1);
        @(negedge clk);
        check("mask_busy", 32'(busy), 32'h0);
        check("mask_mem_en", 32'(mem_en), 32'h0);
        req[1] = 1'b0;
        @(negedge clk);
        check("mask_busy_after", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);

        // Fairness: four simultaneous requests right after reset.
        do_reset();
        set_port(0, 1'b0, 7'h20, 8'h00);
        set_port(1, 1'b0, 7'h1F, 8'h00);
        set_port(2, 1'b0, 7'h05, 8'h00);
        set_port(3, 1'b0, 7'h20, 8'h00);
        expect_done(0, 8'hA5, cyc + 3);
        expect_done(1, 8'h3C, cyc + 6);
        expect_done(2, 8'h77, cyc + 9);
        expect_done(3, 8'hA5, cyc + 12);
        drain(40);

        // Ports 0 and 3 never drop req until four accesses have completed.
        do_reset();
        set_port(0, 1'b0, 7'h1F, 8'h00);
        set_port(3, 1'b0, 7'h05, 8'h00);
        expect_done(0, 8'h3C, cyc + 3);
        expect_done(3, 8'h77, cyc + 6);
        expect_done(0, 8'h3C, cyc + 9);
        expect_done(3, 8'h77, cyc + 12);
        n = 0;
        begin
            int seen;
            seen = 0;
            while (seen < 4 && n < 40) begin
                @(negedge clk);
                if (done != 4'b0) seen++;
                n++;
            end
            check("held_count", 32'(seen), 32'h4);
        end
        req = 4'b0;
        repeat (5) @(negedge clk);

        check("queue_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
